modexp_controller: RTL and testbench

Sequencer for modular exponentiation, result = base^exponent mod modulus. It uses left-to-right square-and-multiply and drives one external modular-squaring unit and one external modular-multiply unit through their ready/busy/valid handshakes. It sits between the key-generation/encryption control logic and the shared arithmetic units. It owns operand routing and bit scheduling only, and performs no arithmetic itself beyond constant selection.

---
 rtl/modexp_controller.sv | 148 ++++++++++++++
 tb/tb_modexp_controller.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_controller.sv
// Left-to-right square-and-multiply sequencer driving an external modular
// squaring unit and an external modular multiply unit.
module modexp_controller #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned EXP_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 ready_in,
    input  logic [WIDTH-1:0]     base_in,
    input  logic [EXP_WIDTH-1:0] exponent_in,
    input  logic [WIDTH-1:0]     modulus_in,
    output logic [WIDTH-1:0]     result_out,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic                 err_out,
    output logic                 sq_ready_out,
    output logic [WIDTH-1:0]     sq_value_out,
    input  logic                 sq_valid_in,
    input  logic [WIDTH-1:0]     sq_result_in,
    output logic                 mm_ready_out,
    output logic [WIDTH-1:0]     mm_a_out,
    output logic [WIDTH-1:0]     mm_b_out,
    input  logic                 mm_valid_in,
    input  logic [WIDTH-1:0]     mm_result_in,
    output logic [WIDTH-1:0]     modulus_out
);

    localparam int unsigned BLW = $clog2(EXP_WIDTH) + 1;

    typedef enum logic [3:0] {
        StIdle, StCheck, StScan, StNext, StSqReq, StSqWait, StMmReq, StMmWait, StDone
    } state_e;

    state_e               state;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     base_r;
    logic [WIDTH-1:0]     mod_r;
    logic [EXP_WIDTH-1:0] exp_r;
    logic [BLW-1:0]       bits_left;

    logic                 exp_msb;
    logic [EXP_WIDTH-1:0] exp_shl;
    logic [BLW-1:0]       bits_dec;

    assign exp_msb     = exp_r[EXP_WIDTH-1];
    assign exp_shl     = {exp_r[EXP_WIDTH-2:0], 1'b0};
    assign bits_dec    = bits_left - BLW'(1);
    assign modulus_out = mod_r;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= StIdle;
            acc          <= '0;
            base_r       <= '0;
            mod_r        <= '0;
            exp_r        <= '0;
            bits_left    <= '0;
            result_out   <= '0;
            busy_out     <= 1'b0;
            valid_out    <= 1'b0;
            err_out      <= 1'b0;
            sq_ready_out <= 1'b0;
            sq_value_out <= '0;
            mm_ready_out <= 1'b0;
            mm_a_out     <= '0;
            mm_b_out     <= '0;
        end else begin
            // Pulse outputs default low; only the transitions below raise them.
            valid_out    <= 1'b0;
            err_out      <= 1'b0;
            sq_ready_out <= 1'b0;
            mm_ready_out <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (ready_in) begin
                        base_r    <= base_in;
                        exp_r     <= exponent_in;
                        mod_r     <= modulus_in;
                        bits_left <= BLW'(EXP_WIDTH);
                        busy_out  <= 1'b1;
                        state     <= StCheck;
                    end
                end
                StCheck: begin
                    if (mod_r == '0 || mod_r == WIDTH'(1) || exp_r == '0) begin
                        result_out <= (mod_r > WIDTH'(1)) ? WIDTH'(1) : '0;
                        err_out    <= (mod_r == '0);
                        valid_out  <= 1'b1;
                        busy_out   <= 1'b0;
                        state      <= StDone;
                    end else begin
                        state <= StScan;
                    end
                end
                StScan: begin
                    exp_r     <= exp_shl;
                    bits_left <= bits_dec;
                    if (exp_msb) begin
                        acc   <= base_r;
                        state <= StNext;
                    end
                end
                StNext: begin
                    if (bits_left == '0) begin
                        result_out <= acc;
                        valid_out  <= 1'b1;
                        busy_out   <= 1'b0;
                        state      <= StDone;
                    end else begin
                        sq_ready_out <= 1'b1;
                        sq_value_out <= acc;
                        state        <= StSqReq;
                    end
                end
                StSqReq: state <= StSqWait;
                StSqWait: begin
                    if (sq_valid_in) begin
                        acc <= sq_result_in;
                        if (exp_msb) begin
                            // Multiply operand is the fresh square, not the stale acc.
                            mm_ready_out <= 1'b1;
                            mm_a_out     <= sq_result_in;
                            mm_b_out     <= base_r;
                            state        <= StMmReq;
                        end else begin
                            exp_r     <= exp_shl;
                            bits_left <= bits_dec;
                            state     <= StNext;
                        end
                    end
                end
                StMmReq: state <= StMmWait;
                StMmWait: begin
                    if (mm_valid_in) begin
                        acc       <= mm_result_in;
                        exp_r     <= exp_shl;
                        bits_left <= bits_dec;
                        state     <= StNext;
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_controller.sv
// Randomised self-checking bench for modexp_controller with behavioural
// squaring/multiply unit models and an arithmetic reference for modexp.
module tb_modexp_controller;

    localparam int W  = 16;
    localparam int EW = 16;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          ready_in = 1'b0;
    logic [W-1:0]  base_in = '0;
    logic [EW-1:0] exponent_in = '0;
    logic [W-1:0]  modulus_in = '0;
    logic [W-1:0]  result_out;
    logic          busy_out, valid_out, err_out;
    logic          sq_ready_out, mm_ready_out;
    logic [W-1:0]  sq_value_out, mm_a_out, mm_b_out, modulus_out;
    logic          sq_valid_in = 1'b0;
    logic [W-1:0]  sq_result_in = '0;
    logic          mm_valid_in = 1'b0;
    logic [W-1:0]  mm_result_in = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    modexp_controller #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .ready_in     (ready_in),
        .base_in      (base_in),
        .exponent_in  (exponent_in),
        .modulus_in   (modulus_in),
        .result_out   (result_out),
        .busy_out     (busy_out),
        .valid_out    (valid_out),
        .err_out      (err_out),
        .sq_ready_out (sq_ready_out),
        .sq_value_out (sq_value_out),
        .sq_valid_in  (sq_valid_in),
        .sq_result_in (sq_result_in),
        .mm_ready_out (mm_ready_out),
        .mm_a_out     (mm_a_out),
        .mm_b_out     (mm_b_out),
        .mm_valid_in  (mm_valid_in),
        .mm_result_in (mm_result_in),
        .modulus_out  (modulus_out)
    );

    function automatic longint ref_pow(input longint b, input longint e, input longint m);
        longint r;
        if (m == 0) return 0;
        r = 1 % m;
        for (int i = EW - 1; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * b) % m;
        end
        return r;
    endfunction

    function automatic int ref_nsq(input longint e, input longint m);
        if (m < 2) return 0;
        for (int i = EW - 1; i >= 0; i--) if (e[i]) return i;
        return 0;
    endfunction

    function automatic int ref_nmm(input longint e, input longint m);
        int c;
        c = 0;
        if (m < 2 || e == 0) return 0;
        for (int i = 0; i < EW; i++) if (e[i]) c++;
        return c - 1;
    endfunction

    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        longint p;
        if (m == 0) return '0;
        p = (longint'(a) * longint'(b)) % longint'(m);
        return W'(p);
    endfunction

    // Caller must be at a negedge with the DUT idle; returns at the negedge
    // of the idle cycle following valid_out.
    task automatic run_job(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m,
                           input int lat_max, input bit hold_ready, input bit spurious,
                           output logic [W-1:0] res, output logic err,
                           output int nsq, output int nmm, output int cyc);
        bit sq_pend, mm_pend, done;
        int sq_cnt, mm_cnt;
        logic [W-1:0] sq_op, mm_a, mm_b;
        nsq = 0; nmm = 0; cyc = 0; res = '0; err = 1'b0;
        sq_pend = 0; mm_pend = 0; done = 0; sq_cnt = 0; mm_cnt = 0;
        sq_op = '0; mm_a = '0; mm_b = '0;
        if (spurious) begin
            sq_valid_in = 1'b1; sq_result_in = W'($urandom);
            mm_valid_in = 1'b1; mm_result_in = W'($urandom);
            @(negedge clk_in);
            sq_valid_in = 1'b0; mm_valid_in = 1'b0;
        end
        base_in = b; exponent_in = e; modulus_in = m; ready_in = 1'b1;
        @(posedge clk_in);
        for (int k = 1; k <= 4000 && !done; k++) begin
            @(negedge clk_in);
            if (!hold_ready) ready_in = 1'b0;
            sq_valid_in = 1'b0;
            mm_valid_in = 1'b0;
            if (sq_pend) begin
                n_cmp++;
                if (sq_value_out !== sq_op) begin
                    n_bad++;
                    $display("FAIL sq_hold: got %0d expected %0d", sq_value_out, sq_op);
                end
                sq_cnt--;
                if (sq_cnt == 0) begin
                    sq_valid_in = 1'b1; sq_result_in = mod_mul(sq_op, sq_op, m); sq_pend = 0;
                end
            end
            if (mm_pend) begin
                n_cmp++;
                if (mm_a_out !== mm_a || mm_b_out !== mm_b) begin
                    n_bad++;
                    $display("FAIL mm_hold: got %0d,%0d expected %0d,%0d",
                             mm_a_out, mm_b_out, mm_a, mm_b);
                end
                mm_cnt--;
                if (mm_cnt == 0) begin
                    mm_valid_in = 1'b1; mm_result_in = mod_mul(mm_a, mm_b, m); mm_pend = 0;
                end
            end
            if (sq_ready_out) begin
                nsq++;
                n_cmp++;
                if (sq_pend || mm_pend) begin
                    n_bad++;
                    $display("FAIL sq_overlap: got request while a unit is pending");
                end
                sq_pend = 1; sq_op = sq_value_out; sq_cnt = int'($urandom_range(lat_max, 1));
            end
            if (mm_ready_out) begin
                nmm++;
                n_cmp++;
                if (mm_b_out !== b || sq_pend || mm_pend) begin
                    n_bad++;
                    $display("FAIL mm_req: got b=%0d expected %0d (or overlap)", mm_b_out, b);
                end
                mm_pend = 1; mm_a = mm_a_out; mm_b = mm_b_out;
                mm_cnt = int'($urandom_range(lat_max, 1));
            end
            if (spurious && !sq_pend && !mm_pend && !sq_valid_in && !mm_valid_in
                && $urandom_range(2, 0) == 0) begin
                sq_valid_in = 1'b1; sq_result_in = W'($urandom);
                mm_valid_in = 1'b1; mm_result_in = W'($urandom);
            end
            if (valid_out) begin
                done = 1; cyc = k; res = result_out; err = err_out;
                n_cmp++;
                if (busy_out !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_at_done: got %0b expected 0", busy_out);
                end
            end else begin
                n_cmp++;
                if (busy_out !== 1'b1 || err_out !== 1'b0 || modulus_out !== m) begin
                    n_bad++;
                    $display("FAIL busy_phase: got busy=%0b err=%0b mod=%0d expected 1,0,%0d",
                             busy_out, err_out, modulus_out, m);
                end
            end
        end
        ready_in = 1'b0; sq_valid_in = 1'b0; mm_valid_in = 1'b0;
        if (!done) begin
            n_bad++;
            $display("FAIL timeout: got no valid_out expected completion");
        end
        @(negedge clk_in);
        n_cmp++;
        if (valid_out !== 1'b0 || busy_out !== 1'b0) begin
            n_bad++;
            $display("FAIL after_done: got valid=%0b busy=%0b expected 0,0", valid_out, busy_out);
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({result_out, busy_out, valid_out, err_out, sq_ready_out, mm_ready_out,
             sq_value_out, mm_a_out, mm_b_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got nonzero expected all zero");
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic test_known();
        logic [W-1:0] r; logic e; int ns, nm, c;
        run_job(16'd4, 16'd13, 16'd497, 20, 0, 0, r, e, ns, nm, c);
        n_cmp++;
        if (r !== 16'd445 || ns != 3 || nm != 2 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL known_4_13_497: got r=%0d sq=%0d mm=%0d expected 445,3,2", r, ns, nm);
        end
        run_job(16'd3, 16'd5, 16'd7, 20, 0, 0, r, e, ns, nm, c);
        n_cmp++;
        if (r !== 16'd5 || ns != 2 || nm != 1) begin
            n_bad++;
            $display("FAIL known_3_5_7: got r=%0d sq=%0d mm=%0d expected 5,2,1", r, ns, nm);
        end
    endtask

    task automatic test_trivial();
        logic [W-1:0] r; logic e; int ns, nm, c;
        run_job(16'd5, 16'd0, 16'd497, 4, 0, 0, r, e, ns, nm, c);
        n_cmp++;
        if (r !== 16'd1 || c != 2 || e !== 1'b0 || ns != 0 || nm != 0) begin
            n_bad++;
            $display("FAIL exp_zero: got r=%0d cyc=%0d err=%0b expected 1,2,0", r, c, e);
        end
        run_job(16'd0, 16'd9, 16'd1, 4, 0, 0, r, e, ns, nm, c);
        n_cmp++;
        if (r !== 16'd0 || c != 2 || e !== 1'b0 || ns != 0 || nm != 0) begin
            n_bad++;
            $display("FAIL mod_one: got r=%0d cyc=%0d err=%0b expected 0,2,0", r, c, e);
        end
        run_job(16'd5, 16'd9, 16'd0, 4, 0, 0, r, e, ns, nm, c);
        n_cmp++;
        if (r !== 16'd0 || c != 2 || e !== 1'b1 || ns != 0 || nm != 0) begin
            n_bad++;
            $display("FAIL mod_zero: got r=%0d cyc=%0d err=%0b expected 0,2,1", r, c, e);
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] r; logic e; int ns, nm, c; longint exp_r;
        run_job(16'd7, 16'd1, 16'd10, 5, 0, 0, r, e, ns, nm, c);
        n_cmp++;
        if (r !== 16'd7 || ns != 0 || nm != 0) begin
            n_bad++;
            $display("FAIL exp_one: got r=%0d sq=%0d mm=%0d expected 7,0,0", r, ns, nm);
        end
        exp_r = ref_pow(2, longint'(1) << (EW - 1), 65521);
        run_job(16'd2, 16'h8000, 16'd65521, 5, 0, 0, r, e, ns, nm, c);
        n_cmp++;
        if (longint'(r) != exp_r || ns != EW - 1 || nm != 0) begin
            n_bad++;
            $display("FAIL exp_top_bit: got r=%0d sq=%0d mm=%0d expected %0d,%0d,0",
                     r, ns, nm, exp_r, EW - 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r, b, m; logic [EW-1:0] x; logic e; int ns, nm, c;
        for (int i = 0; i < 16; i++) begin
            m = W'($urandom_range(65535, 2));
            b = W'($urandom % m);
            x = (i % 4 == 0) ? EW'($urandom_range(15, 0)) : EW'($urandom);
            run_job(b, x, m, 6, 0, 0, r, e, ns, nm, c);
            n_cmp++;
            if (longint'(r) != ref_pow(b, x, m) || ns != ref_nsq(x, m) || nm != ref_nmm(x, m)
                || e !== 1'b0) begin
                n_bad++;
                $display("FAIL random: b=%0d e=%0d m=%0d got r=%0d sq=%0d mm=%0d expected %0d,%0d,%0d",
                         b, x, m, r, ns, nm, ref_pow(b, x, m), ref_nsq(x, m), ref_nmm(x, m));
            end
        end
    endtask

    task automatic test_hold_spurious();
        logic [W-1:0] r, b, m; logic [EW-1:0] x; logic e; int ns, nm, c;
        run_job(16'd4, 16'd13, 16'd497, 8, 1, 1, r, e, ns, nm, c);
        n_cmp++;
        if (r !== 16'd445 || ns != 3 || nm != 2) begin
            n_bad++;
            $display("FAIL spurious_known: got r=%0d sq=%0d mm=%0d expected 445,3,2", r, ns, nm);
        end
        for (int i = 0; i < 4; i++) begin
            m = W'($urandom_range(65535, 2));
            b = W'($urandom % m);
            x = EW'($urandom);
            run_job(b, x, m, 8, 1, 1, r, e, ns, nm, c);
            n_cmp++;
            if (longint'(r) != ref_pow(b, x, m) || ns != ref_nsq(x, m) || nm != ref_nmm(x, m)) begin
                n_bad++;
                $display("FAIL spurious_random: got r=%0d expected %0d", r, ref_pow(b, x, m));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r; logic e; int ns, nm, c;
        run_job(16'd4, 16'd13, 16'd497, 3, 0, 0, r, e, ns, nm, c);
        run_job(16'd3, 16'd5, 16'd7, 3, 0, 0, r, e, ns, nm, c);
        n_cmp++;
        if (r !== 16'd5 || ns != 2 || nm != 1) begin
            n_bad++;
            $display("FAIL b2b_second: got r=%0d sq=%0d mm=%0d expected 5,2,1", r, ns, nm);
        end
        run_job(16'd9, 16'd0, 16'd11, 3, 0, 0, r, e, ns, nm, c);
        n_cmp++;
        if (r !== 16'd1 || c != 2) begin
            n_bad++;
            $display("FAIL b2b_third: got r=%0d cyc=%0d expected 1,2", r, c);
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen_mm, sq_due; logic [W-1:0] op, r; logic e; int ns, nm, c;
        seen_mm = 0; sq_due = 0; op = '0;
        base_in = 16'd4; exponent_in = 16'd13; modulus_in = 16'd497; ready_in = 1'b1;
        @(posedge clk_in);
        for (int k = 0; k < 500 && !seen_mm; k++) begin
            @(negedge clk_in);
            ready_in = 1'b0; sq_valid_in = 1'b0;
            if (sq_due) begin
                sq_valid_in = 1'b1; sq_result_in = mod_mul(op, op, 16'd497); sq_due = 0;
            end
            if (sq_ready_out) begin sq_due = 1; op = sq_value_out; end
            if (mm_ready_out) seen_mm = 1;
        end
        sq_valid_in = 1'b0;
        n_cmp++;
        if (!seen_mm) begin
            n_bad++;
            $display("FAIL reach_mm_wait: got no mm request expected one");
        end
        @(negedge clk_in);
        @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        n_cmp++;
        if ({result_out, busy_out, valid_out, err_out, sq_ready_out, mm_ready_out,
             sq_value_out, mm_a_out, mm_b_out} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got busy=%0b result=%0d expected all zero",
                     busy_out, result_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        mm_valid_in = 1'b1; mm_result_in = 16'h1234;
        @(negedge clk_in);
        mm_valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            n_cmp++;
            if (busy_out !== 1'b0 || valid_out !== 1'b0 || result_out !== '0) begin
                n_bad++;
                $display("FAIL late_valid: got busy=%0b valid=%0b result=%0d expected 0,0,0",
                         busy_out, valid_out, result_out);
            end
        end
        run_job(16'd4, 16'd13, 16'd497, 10, 0, 0, r, e, ns, nm, c);
        n_cmp++;
        if (r !== 16'd445 || ns != 3 || nm != 2) begin
            n_bad++;
            $display("FAIL post_reset_job: got r=%0d expected 445", r);
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_trivial();
        test_edges();
        test_random();
        test_hold_spurious();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
